// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 key event decoder feeding a small FIFO.
// The FIFO is read by a PicoBlaze through its port_id/read_strobe I/O path.
module ps2_key_event_fifo #(
  parameter int          DEPTH       = 4,
  parameter logic [7:0]  DATA_PORT   = 8'h0A,
  parameter logic [7:0]  STAT_PORT   = 8'h0B,
  parameter bit          REPORT_MAKE = 1'b0,
  parameter logic [15:0] TIMEOUT     = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_out,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] dato,
  output logic       got_code_tick,
  output logic       fifo_empty,
  output logic       fifo_full
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
  localparam logic [7:0]    C_E0   = 8'hE0;
  localparam logic [7:0]    C_F0   = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_tmo;
  logic          w_tmo_hit;
  logic          w_push_req;
  logic [9:0]    w_push_data;
  logic          w_push_ok;
  logic          w_pop;
  logic          w_stat_rd;
  logic          w_ovf_set;
  logic          r_ovf;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic [9:0]    w_head;

  assign w_tmo_hit = (r_state != S_IDLE) && (r_tmo == TIMEOUT - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A new byte always takes priority over an expiring prefix timer.
  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    w_push_data = {2'b00, scan_out};
    if (scan_done_tick) begin
      case (r_state)
        S_IDLE: begin
          if (scan_out == C_E0)      w_state_nxt = S_EXT;
          else if (scan_out == C_F0) w_state_nxt = S_BRK;
          else                       w_push_req  = REPORT_MAKE;
        end
        S_EXT: begin
          if (scan_out == C_F0)      w_state_nxt = S_EXT_BRK;
          else if (scan_out != C_E0) begin
            w_push_req  = REPORT_MAKE;
            w_push_data = {2'b01, scan_out};
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (scan_out == C_E0)      w_state_nxt = S_EXT_BRK;
          else if (scan_out != C_F0) begin
            w_push_req  = 1'b1;
            w_push_data = {2'b10, scan_out};
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          if (scan_out != C_E0 && scan_out != C_F0) begin
            w_push_req  = 1'b1;
            w_push_data = {2'b11, scan_out};
            w_state_nxt = S_IDLE;
          end
        end
      endcase
    end else if (w_tmo_hit) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_tmo <= 16'd0;
    else if (scan_done_tick || r_state == S_IDLE || w_tmo_hit)
      r_tmo <= 16'd0;
    else
      r_tmo <= r_tmo + 16'd1;
  end

  assign fifo_empty = (r_count == '0);
  assign fifo_full  = (r_count == C_FULL);
  assign w_pop      = read_strobe && (port_id == DATA_PORT) && !fifo_empty;
  assign w_stat_rd  = read_strobe && (port_id == STAT_PORT);
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_push_ok  = w_push_req && (!fifo_full || w_pop);
  assign w_ovf_set  = w_push_req && !w_push_ok;
  assign w_head     = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr          <= '0;
      r_rd          <= '0;
      r_count       <= '0;
      r_ovf         <= 1'b0;
      got_code_tick <= 1'b0;
    end else begin
      got_code_tick <= w_push_ok;
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_stat_rd) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    dato = 8'h00;
    if (port_id == DATA_PORT) begin
      if (!fifo_empty) dato = w_head[7:0];
    end else if (port_id == STAT_PORT) begin
      dato = {(fifo_empty ? 2'b00 : w_head[9:8]), 3'b000, r_ovf, fifo_full, fifo_empty};
    end
  end

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Scoreboard bench: dut0 reports breaks only with a short prefix timeout,
// dut1 reports make and break events.
module tb_ps2_key_event_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scan_out;
  logic [7:0] port_id;
  logic       tick0, tick1, rs0, rs1;
  logic [7:0] dato0, dato1;
  logic       got0, got1, emp0, emp1, full0, full1;

  int checks = 0;
  int errors = 0;
  int ngot0  = 0;
  int ngot1  = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  always #5 clk = ~clk;

  ps2_key_event_fifo #(.DEPTH(4), .REPORT_MAKE(1'b0), .TIMEOUT(16'd100)) dut0 (
    .clk(clk), .reset(reset), .scan_done_tick(tick0), .scan_out(scan_out),
    .port_id(port_id), .read_strobe(rs0), .dato(dato0), .got_code_tick(got0),
    .fifo_empty(emp0), .fifo_full(full0));

  ps2_key_event_fifo #(.DEPTH(4), .REPORT_MAKE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .scan_done_tick(tick1), .scan_out(scan_out),
    .port_id(port_id), .read_strobe(rs1), .dato(dato1), .got_code_tick(got1),
    .fifo_empty(emp1), .fifo_full(full1));

  always @(negedge clk) begin
    if (got0) ngot0++;
    if (got1) ngot1++;
  end

  task automatic send(input int d, input logic [7:0] b);
    @(negedge clk);
    scan_out = b;
    if (d == 0) tick0 = 1'b1; else tick1 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0;
    tick1 = 1'b0;
  endtask

  task automatic expect_ev(input int d, input logic [9:0] e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    q0.delete();
    q1.delete();
  endtask

  task automatic rd_data(input int d, input string name);
    logic [7:0] obs, exp;
    @(negedge clk);
    port_id = 8'h0A;
    if (d == 0) rs0 = 1'b1; else rs1 = 1'b1;
    #1;
    obs = (d == 0) ? dato0 : dato1;
    exp = 8'h00;
    if (d == 0 && q0.size() > 0) exp = q0.pop_front() & 10'h0FF;
    else if (d == 1 && q1.size() > 0) exp = q1.pop_front() & 10'h0FF;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s dut%0d data got %h expected %h", name, d, obs, exp);
    end
    @(negedge clk);
    rs0 = 1'b0;
    rs1 = 1'b0;
    port_id = 8'h00;
  endtask

  task automatic rd_stat(input int d, input logic ovf, input string name);
    logic [7:0] obs, exp;
    logic [9:0] hd;
    int         n;
    @(negedge clk);
    port_id = 8'h0B;
    if (d == 0) rs0 = 1'b1; else rs1 = 1'b1;
    #1;
    obs = (d == 0) ? dato0 : dato1;
    n   = (d == 0) ? q0.size() : q1.size();
    hd  = 10'h000;
    if (n > 0) hd = (d == 0) ? q0[0] : q1[0];
    exp = {hd[9:8], 3'b000, ovf, (n == 4), (n == 0)};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s dut%0d status got %h expected %h", name, d, obs, exp);
    end
    @(negedge clk);
    rs0 = 1'b0;
    rs1 = 1'b0;
    port_id = 8'h00;
  endtask

  task automatic test_reset();
    pulse_reset();
    #1;
    checks++;
    if ({emp0, full0, got0, emp1, full1, got1} !== 6'b100_100) begin
      errors++;
      $display("FAIL reset_flags got %b expected 100100", {emp0, full0, got0, emp1, full1, got1});
    end
    rd_stat(0, 1'b0, "reset_stat");
    rd_stat(1, 1'b0, "reset_stat");
    rd_data(0, "reset_empty_data");
  endtask

  task automatic test_break();
    int n;
    n = ngot0;
    send(0, 8'h1C);
    send(0, 8'hF0);
    expect_ev(0, {2'b10, 8'h1C});
    send(0, 8'h1C);
    @(negedge clk);
    checks++;
    if (ngot0 - n != 1) begin
      errors++;
      $display("FAIL break_tick_count got %0d expected 1", ngot0 - n);
    end
    rd_stat(0, 1'b0, "break_stat");
    rd_data(0, "break_data");
    rd_stat(0, 1'b0, "break_stat_after_pop");
  endtask

  task automatic test_ext_break();
    int n;
    send(0, 8'hE0);
    send(0, 8'hF0);
    expect_ev(0, {2'b11, 8'h75});
    send(0, 8'h75);
    rd_stat(0, 1'b0, "ext_break_stat");
    rd_data(0, "ext_break_data");
    n = ngot0;
    send(0, 8'hE0);
    send(0, 8'h6B);
    @(negedge clk);
    checks++;
    if (ngot0 != n || emp0 !== 1'b1) begin
      errors++;
      $display("FAIL ext_make_ignored got ticks %0d empty %b expected 0 and 1", ngot0 - n, emp0);
    end
    send(1, 8'hE0);
    expect_ev(1, {2'b01, 8'h6B});
    send(1, 8'h6B);
    rd_stat(1, 1'b0, "ext_make_stat");
    rd_data(1, "ext_make_data");
  endtask

  task automatic test_overflow();
    int n;
    logic [7:0] codes [4];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23};
    n = ngot1;
    for (int i = 0; i < 4; i++) begin
      expect_ev(1, {2'b00, codes[i]});
      send(1, codes[i]);
    end
    send(1, 8'h2B);
    @(negedge clk);
    checks++;
    if (full1 !== 1'b1 || emp1 !== 1'b0 || ngot1 - n != 4) begin
      errors++;
      $display("FAIL overflow_flags got full %b empty %b ticks %0d expected 1 0 4", full1, emp1, ngot1 - n);
    end
    rd_stat(1, 1'b1, "overflow_stat");
    rd_stat(1, 1'b0, "overflow_cleared");
    for (int i = 0; i < 5; i++) rd_data(1, "overflow_drain");
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] obs;
    for (int i = 0; i < 4; i++) begin
      expect_ev(1, {2'b00, 8'h11 + 8'(i)});
      send(1, 8'h11 + 8'(i));
    end
    n = ngot1;
    @(negedge clk);
    scan_out = 8'h15;
    tick1    = 1'b1;
    port_id  = 8'h0A;
    rs1      = 1'b1;
    #1;
    obs = dato1;
    checks++;
    if (obs !== q1[0][7:0]) begin
      errors++;
      $display("FAIL b2b_head got %h expected %h", obs, q1[0][7:0]);
    end
    void'(q1.pop_front());
    q1.push_back({2'b00, 8'h15});
    @(negedge clk);
    tick1   = 1'b0;
    rs1     = 1'b0;
    port_id = 8'h00;
    checks++;
    if (full1 !== 1'b1 || ngot1 - n != 1) begin
      errors++;
      $display("FAIL b2b_full got full %b ticks %0d expected 1 1", full1, ngot1 - n);
    end
    rd_stat(1, 1'b0, "b2b_stat");
    for (int i = 0; i < 5; i++) rd_data(1, "b2b_drain");
  endtask

  task automatic test_timeout();
    int n;
    n = ngot0;
    send(0, 8'hF0);
    repeat (100) @(negedge clk);
    send(0, 8'h1C);
    @(negedge clk);
    checks++;
    if (ngot0 != n || emp0 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_discard got ticks %0d empty %b expected 0 and 1", ngot0 - n, emp0);
    end
    send(0, 8'hF0);
    repeat (50) @(negedge clk);
    expect_ev(0, {2'b10, 8'h1C});
    send(0, 8'h1C);
    rd_stat(0, 1'b0, "timeout_held_stat");
    rd_data(0, "timeout_held_data");
  endtask

  task automatic test_reset_mid();
    send(0, 8'hF0);
    send(0, 8'h4D);
    send(0, 8'hE0);
    send(0, 8'hF0);
    pulse_reset();
    #1;
    checks++;
    if (emp0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_empty got %b expected 1", emp0);
    end
    send(0, 8'h1C);
    send(0, 8'hF0);
    expect_ev(0, {2'b10, 8'h1C});
    send(0, 8'h1C);
    rd_stat(0, 1'b0, "reset_mid_stat");
    rd_data(0, "reset_mid_data");
    rd_data(0, "reset_mid_single");
  endtask

  initial begin
    reset    = 1'b0;
    scan_out = 8'h00;
    port_id  = 8'h00;
    tick0    = 1'b0;
    tick1    = 1'b0;
    rs0      = 1'b0;
    rs1      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_break();
    test_ext_break();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
